if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the data and address width.
REQ-002 The module SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 clk  input  1  clock; all state SHALL update on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 STALL  input  1  downstream IF/ID is holding; the current output is not consumed.
REQ-006 REDIRECT  input  1  branch/jump/flush taken this cycle.
REQ-007 REDIRECT_PC  input  WIDTH  new fetch address, valid with REDIRECT.
REQ-008 IMEM_REQ  output  1  fetch request to instruction memory.
REQ-009 IMEM_ADDR  output  WIDTH  fetch address, word aligned.
REQ-010 IMEM_GNT  input  1  memory accepts the request this cycle.
REQ-011 IMEM_RVALID  input  1  response data valid, earliest the cycle after grant.
REQ-012 IMEM_RDATA  input  WIDTH  fetched instruction word.
REQ-013 PC_OUT  output  WIDTH  address of the presented instruction, registered.
REQ-014 INSTRUCTION_OUT  output  WIDTH  presented instruction, registered.
REQ-015 VALID_OUT  output  1  PC_OUT/INSTRUCTION_OUT hold a real instruction.

Function
REQ-016 The FSM SHALL have states REQ (IMEM_REQ=1), WAIT (granted, awaiting RVALID), DISCARD (awaiting a stale RVALID) and HOLD (skid buffer full, no request).
REQ-017 In REQ, IMEM_GNT=1 SHALL move the FSM to WAIT; otherwise it SHALL stay in REQ with IMEM_ADDR unchanged unless REDIRECT.
REQ-018 A single request SHALL be outstanding at most; peak throughput SHALL be one instruction per two cycles (REQ, then WAIT with RVALID).
REQ-019 On RVALID in WAIT, {pc, IMEM_RDATA} SHALL load the output registers when the slot is free (VALID_OUT=0 or STALL=0), else the one-entry skid buffer; pc SHALL advance by 4 modulo 2^WIDTH.
REQ-020 After the response, the FSM SHALL return to REQ if the skid buffer is empty, else enter HOLD.
REQ-021 In HOLD, when STALL=0 the skid entry SHALL move to the output registers and the FSM SHALL return to REQ.
REQ-022 When STALL=0 and no new entry is loaded, VALID_OUT SHALL clear on the next edge.
REQ-023 REDIRECT SHALL take priority over STALL and GNT: pc <= {REDIRECT_PC[WIDTH-1:2], 2'b00}; VALID_OUT and the skid entry SHALL clear on the next edge.
REQ-024 REDIRECT in WAIT, or in REQ with GNT=1 in the same cycle, SHALL enter DISCARD; the next RVALID SHALL be dropped and the FSM SHALL then enter REQ at the new pc.
REQ-025 REDIRECT in REQ without GNT SHALL stay in REQ with IMEM_ADDR updated on the next cycle; REDIRECT in HOLD SHALL enter REQ.
REQ-026 REDIRECT coincident with RVALID in WAIT SHALL drop that response and enter REQ.
REQ-027 When VALID_OUT=0, INSTRUCTION_OUT SHALL be 32'h0000_0013 (NOP).

Reset
REQ-028 While rst=0 on a clock edge: state=REQ, pc=RESET_PC, VALID_OUT=0, PC_OUT=0, INSTRUCTION_OUT=32'h0000_0013, skid empty.
REQ-029 Reset mid-transaction SHALL abandon the outstanding request; an RVALID arriving in the first cycle after reset release SHALL be ignored.
REQ-030 IMEM_REQ SHALL be 0 while rst=0 and 1 in the first cycle after release.

Configuration
REQ-031 With IF_FAULT_EN defined, the module SHALL add input IMEM_ERR (qualifies RVALID) and output FAULT_OUT (reset 0).
REQ-032 An error response SHALL present VALID_OUT=1, FAULT_OUT=1, INSTRUCTION_OUT=0, and stop fetching (IMEM_REQ=0) until REDIRECT, which clears FAULT_OUT.
REQ-033 Without IF_FAULT_EN, these ports SHALL be absent and responses SHALL always be treated as good.

Verification
REQ-034 Reset release, GNT and RVALID one cycle later each time -> PCs 0,4,8 presented with VALID_OUT=1 every second cycle.
REQ-035 STALL held 4 cycles with a response in flight -> skid fills, state HOLD, IMEM_REQ=0; STALL drops -> PCs presented in order, none lost or duplicated.
REQ-036 REDIRECT to 0x104 while in WAIT -> stale RVALID dropped, next IMEM_ADDR=0x104, VALID_OUT=0 for at least one cycle.
REQ-037 REDIRECT to 0x203 coincident with GNT -> DISCARD entered, next address 0x200.
REQ-038 GNT held low 5 cycles -> IMEM_REQ stays 1, IMEM_ADDR stable.
REQ-039 IF_FAULT_EN, IMEM_ERR=1 on fetch at 0x8 -> FAULT_OUT=1, fetch halts; REDIRECT to 0x0 -> FAULT_OUT=0, fetch resumes at 0x0.

Source files
------------

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch -- instruction fetch stage with a one-entry skid buffer.
//
// Issues one instruction-memory request at a time (REQ -> WAIT), so the peak
// rate is one instruction every two cycles. A returned instruction goes to the
// output registers if the downstream slot is free, otherwise to a one-entry
// skid buffer (state HOLD, no new requests until it drains). A redirect
// re-targets the fetch address and flushes everything presented or buffered.
// A response already in flight when the redirect happens is dropped in DISCARD.
//
// Optional feature macro: IF_FAULT_EN
//   Adds i_imem_err (qualifies i_imem_rvalid) and o_fault_out. An error
//   response is presented as a valid all-zero instruction with o_fault_out=1,
//   and fetching halts until the next redirect, which clears o_fault_out.
//
// Ports
//   clk               clock, all state updates on its rising edge
//   rst               synchronous active-low reset
//   i_stall           downstream is holding; the presented output is not consumed
//   i_redirect        branch/jump/flush this cycle
//   i_redirect_pc     new fetch address (low two bits ignored)
//   o_imem_req        fetch request to instruction memory
//   o_imem_addr       word-aligned fetch address
//   i_imem_gnt        memory accepts the request this cycle
//   i_imem_rvalid     response valid (earliest the cycle after grant)
//   i_imem_rdata      fetched instruction word
//   i_imem_err        (IF_FAULT_EN) response is an error
//   o_pc_out          address of the presented instruction
//   o_instruction_out presented instruction (NOP when o_valid_out=0)
//   o_valid_out       o_pc_out/o_instruction_out hold a real instruction
//   o_fault_out       (IF_FAULT_EN) presented instruction faulted
// -----------------------------------------------------------------------------
module if_fetch #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stall,
  input  logic             i_redirect,
  input  logic [WIDTH-1:0] i_redirect_pc,
  output logic             o_imem_req,
  output logic [WIDTH-1:0] o_imem_addr,
  input  logic             i_imem_gnt,
  input  logic             i_imem_rvalid,
  input  logic [WIDTH-1:0] i_imem_rdata,
`ifdef IF_FAULT_EN
  input  logic             i_imem_err,
  output logic             o_fault_out,
`endif
  output logic [WIDTH-1:0] o_pc_out,
  output logic [WIDTH-1:0] o_instruction_out,
  output logic             o_valid_out
);

  localparam logic [WIDTH-1:0] NOP = WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,  // request outstanding on the bus
    S_WAIT    = 2'd1,  // granted, waiting for the response
    S_DISCARD = 2'd2,  // granted before a redirect; drop the next response
    S_HOLD    = 2'd3   // skid buffer full, no request
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic             r_imem_req;
  logic             r_halt;
  logic             r_valid;
  logic [WIDTH-1:0] r_pc_out;
  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_skid_pc;
  logic [WIDTH-1:0] r_skid_instr;

  logic             w_err;
  logic             w_fire;
  logic             w_slot_free;
  logic             w_rsp_take;
  logic             w_skid_drain;
  logic [WIDTH-1:0] w_rsp_instr;
  logic [WIDTH-1:0] w_pc_redirect;
  logic [WIDTH-1:0] w_pc_next;

  // A grant only counts while the request is actually driven; this keeps a
  // grant seen in the first cycle after reset release from being taken.
  assign w_fire        = r_imem_req & i_imem_gnt;
  assign w_slot_free   = ~r_valid | ~i_stall;
  assign w_rsp_take    = (r_state == S_WAIT) & i_imem_rvalid & ~i_redirect;
  assign w_skid_drain  = (r_state == S_HOLD) & ~i_stall & ~i_redirect;
  assign w_rsp_instr   = w_err ? '0 : i_imem_rdata;
  assign w_pc_redirect = i_redirect_pc & ~WIDTH'(3);
  assign w_pc_next     = r_pc + WIDTH'(4);  // wraps modulo 2^WIDTH

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_imem_req   <= 1'b0;
      r_halt       <= 1'b0;
      r_valid      <= 1'b0;
      r_pc_out     <= '0;
      r_instr      <= NOP;
      r_skid_pc    <= '0;
      r_skid_instr <= NOP;
    end else if (i_redirect) begin
      // Redirect beats stall and grant: flush output and skid, re-target pc.
      r_pc    <= w_pc_redirect;
      r_halt  <= 1'b0;
      r_valid <= 1'b0;
      r_instr <= NOP;
      case (r_state)
        S_REQ: begin
          r_state    <= w_fire ? S_DISCARD : S_REQ;
          r_imem_req <= ~w_fire;
        end
        S_WAIT, S_DISCARD: begin
          // A response arriving now is the stale one: drop it and go again.
          r_state    <= i_imem_rvalid ? S_REQ : S_DISCARD;
          r_imem_req <= i_imem_rvalid;
        end
        default: begin  // S_HOLD
          r_state    <= S_REQ;
          r_imem_req <= 1'b1;
        end
      endcase
    end else begin
      // NOTE: non-blocking assignments later in this block override these
      // defaults, so a newly loaded entry wins over the consume-and-clear.
      if (!i_stall) begin
        r_valid <= 1'b0;
        r_instr <= NOP;
      end
      case (r_state)
        S_REQ: begin
          if (w_fire) begin
            r_state    <= S_WAIT;
            r_imem_req <= 1'b0;
          end else begin
            r_imem_req <= ~r_halt;
          end
        end
        S_WAIT: begin
          if (w_rsp_take) begin
            r_pc <= w_pc_next;
            if (w_err) r_halt <= 1'b1;
            if (w_slot_free) begin
              r_valid    <= 1'b1;
              r_pc_out   <= r_pc;
              r_instr    <= w_rsp_instr;
              r_state    <= S_REQ;
              r_imem_req <= ~w_err;
            end else begin
              r_skid_pc    <= r_pc;
              r_skid_instr <= w_rsp_instr;
              r_state      <= S_HOLD;
              r_imem_req   <= 1'b0;
            end
          end
        end
        S_DISCARD: begin
          if (i_imem_rvalid) begin
            r_state    <= S_REQ;
            r_imem_req <= ~r_halt;
          end
        end
        default: begin  // S_HOLD
          if (w_skid_drain) begin
            r_valid    <= 1'b1;
            r_pc_out   <= r_skid_pc;
            r_instr    <= r_skid_instr;
            r_state    <= S_REQ;
            r_imem_req <= ~r_halt;
          end
        end
      endcase
    end
  end

`ifdef IF_FAULT_EN
  logic r_skid_err;
  logic r_fault_out;

  // Fault flag follows its entry: set when the errored entry reaches the
  // output registers (directly or via the skid), held until a redirect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_skid_err  <= 1'b0;
      r_fault_out <= 1'b0;
    end else if (i_redirect) begin
      r_skid_err  <= 1'b0;
      r_fault_out <= 1'b0;
    end else begin
      if (w_rsp_take) begin
        if (w_slot_free) begin
          if (w_err) r_fault_out <= 1'b1;
        end else begin
          r_skid_err <= w_err;
        end
      end
      if (w_skid_drain && r_skid_err) r_fault_out <= 1'b1;
    end
  end

  assign w_err       = i_imem_err;
  assign o_fault_out = r_fault_out;
`else
  assign w_err = 1'b0;
`endif

  assign o_imem_req        = r_imem_req;
  assign o_imem_addr       = r_pc;
  assign o_pc_out          = r_pc_out;
  assign o_instruction_out = r_instr;
  assign o_valid_out       = r_valid;

endmodule

// File: tb/tb_if_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_fetch -- directed, table-driven bench for if_fetch.
// Each table row gives the inputs for one cycle and the outputs expected right
// after that cycle's rising edge. A streaming sequence with a small memory
// model then checks in-order delivery under a stall pattern.
// -----------------------------------------------------------------------------
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] A   = 32'hA000_0000;
  localparam logic [31:0] K   = 32'h5A5A_0000;

  logic        clk;
  logic        rst;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_pc_out;
  logic [31:0] o_instruction_out;
  logic        o_valid_out;
`ifdef IF_FAULT_EN
  logic        i_imem_err;
  logic        o_fault_out;
`endif

  if_fetch #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_stall           (i_stall),
    .i_redirect        (i_redirect),
    .i_redirect_pc     (i_redirect_pc),
    .o_imem_req        (o_imem_req),
    .o_imem_addr       (o_imem_addr),
    .i_imem_gnt        (i_imem_gnt),
    .i_imem_rvalid     (i_imem_rvalid),
    .i_imem_rdata      (i_imem_rdata),
`ifdef IF_FAULT_EN
    .i_imem_err        (i_imem_err),
    .o_fault_out       (o_fault_out),
`endif
    .o_pc_out          (o_pc_out),
    .o_instruction_out (o_instruction_out),
    .o_valid_out       (o_valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        gnt;
    logic        rv;
    logic        err;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic        e_fault;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void add(input logic rs, st, rd, input logic [31:0] rpc,
                              input logic g, rv, er, input logic [31:0] rdata,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_pc,
                              input logic [31:0] e_ins, input logic e_fault);
    vec_t v;
    v.rst = rs; v.stall = st; v.redir = rd; v.rpc = rpc;
    v.gnt = g; v.rv = rv; v.err = er; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_ins = e_ins; v.e_fault = e_fault;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Watchdog: the bench never waits on a DUT event, but guard anyway.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic        pend;
    logic [31:0] pend_addr;
    logic [31:0] exp_pc;
    int          consumed;
    logic [59:0] pat;

    rst = 1'b0; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
`ifdef IF_FAULT_EN
    i_imem_err = 1'b0;
`endif

    //   rst st rd rpc          g rv er rdata          req addr         v pc_out       instr       flt
    // Reset; grant/response during reset and in the first released cycle ignored.
    add(0, 0, 0, 32'h0,       0, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,       NOP,        0);
    add(0, 0, 0, 32'h0,       1, 1, 0, 32'h1111_1111, 0, 32'h0,        0, 32'h0,       NOP,        0);
    add(1, 0, 0, 32'h0,       1, 1, 0, 32'h2222_2222, 1, 32'h0,        0, 32'h0,       NOP,        0);
    // Back-to-back fetch: PCs 0,4,8 every second cycle.
    add(1, 0, 0, 32'h0,       1, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,       NOP,        0);
    add(1, 0, 0, 32'h0,       0, 1, 0, A|32'h0,       1, 32'h4,        1, 32'h0,       A|32'h0,    0);
    add(1, 0, 0, 32'h0,       1, 0, 0, 32'h0,         0, 32'h4,        0, 32'h0,       NOP,        0);
    add(1, 0, 0, 32'h0,       0, 1, 0, A|32'h4,       1, 32'h8,        1, 32'h4,       A|32'h4,    0);
    add(1, 0, 0, 32'h0,       1, 0, 0, 32'h0,         0, 32'h8,        0, 32'h4,       NOP,        0);
    add(1, 0, 0, 32'h0,       0, 1, 0, A|32'h8,       1, 32'hC,        1, 32'h8,       A|32'h8,    0);
    // Stall 4 cycles with a response in flight: skid fills, no request.
    add(1, 1, 0, 32'h0,       1, 0, 0, 32'h0,         0, 32'hC,        1, 32'h8,       A|32'h8,    0);
    add(1, 1, 0, 32'h0,       0, 1, 0, A|32'hC,       0, 32'h10,       1, 32'h8,       A|32'h8,    0);
    add(1, 1, 0, 32'h0,       0, 0, 0, 32'h0,         0, 32'h10,       1, 32'h8,       A|32'h8,    0);
    add(1, 1, 0, 32'h0,       0, 0, 0, 32'h0,         0, 32'h10,       1, 32'h8,       A|32'h8,    0);
    add(1, 0, 0, 32'h0,       0, 0, 0, 32'h0,         1, 32'h10,       1, 32'hC,       A|32'hC,    0);
    // Grant low 5 cycles: request held, address stable.
    for (int i = 0; i < 5; i++)
      add(1, 0, 0, 32'h0,     0, 0, 0, 32'h0,         1, 32'h10,       0, 32'hC,       NOP,        0);
    // Redirect to 0x104 while in WAIT: stale response dropped.
    add(1, 0, 0, 32'h0,       1, 0, 0, 32'h0,         0, 32'h10,       0, 32'hC,       NOP,        0);
    add(1, 0, 1, 32'h104,     0, 0, 0, 32'h0,         0, 32'h104,      0, 32'hC,       NOP,        0);
    add(1, 0, 0, 32'h0,       0, 1, 0, 32'hDEAD_BEEF, 1, 32'h104,      0, 32'hC,       NOP,        0);
    add(1, 0, 0, 32'h0,       1, 0, 0, 32'h0,         0, 32'h104,      0, 32'hC,       NOP,        0);
    add(1, 0, 0, 32'h0,       0, 1, 0, A|32'h104,     1, 32'h108,      1, 32'h104,     A|32'h104,  0);
    // Redirect to 0x203 coincident with grant: DISCARD, next address 0x200.
    add(1, 0, 1, 32'h203,     1, 0, 0, 32'h0,         0, 32'h200,      0, 32'h104,     NOP,        0);
    add(1, 0, 0, 32'h0,       0, 1, 0, 32'hBADB_AD00, 1, 32'h200,      0, 32'h104,     NOP,        0);
    add(1, 0, 0, 32'h0,       1, 0, 0, 32'h0,         0, 32'h200,      0, 32'h104,     NOP,        0);
    add(1, 0, 0, 32'h0,       0, 1, 0, A|32'h200,     1, 32'h204,      1, 32'h200,     A|32'h200,  0);
    // Redirect coincident with the response in WAIT: response dropped.
    add(1, 0, 0, 32'h0,       1, 0, 0, 32'h0,         0, 32'h204,      0, 32'h200,     NOP,        0);
    add(1, 0, 1, 32'h40,      0, 1, 0, 32'hCAFE_0000, 1, 32'h40,       0, 32'h200,     NOP,        0);
    // Redirect in REQ without grant: address updated next cycle.
    add(1, 0, 1, 32'h80,      0, 0, 0, 32'h0,         1, 32'h80,       0, 32'h200,     NOP,        0);
    add(1, 0, 0, 32'h0,       1, 0, 0, 32'h0,         0, 32'h80,       0, 32'h200,     NOP,        0);
    add(1, 0, 0, 32'h0,       0, 1, 0, A|32'h80,      1, 32'h84,       1, 32'h80,      A|32'h80,   0);
    // Redirect in HOLD: skid flushed despite stall.
    add(1, 1, 0, 32'h0,       1, 0, 0, 32'h0,         0, 32'h84,       1, 32'h80,      A|32'h80,   0);
    add(1, 1, 0, 32'h0,       0, 1, 0, A|32'h84,      0, 32'h88,       1, 32'h80,      A|32'h80,   0);
    add(1, 1, 1, 32'h10,      0, 0, 0, 32'h0,         1, 32'h10,       0, 32'h80,      NOP,        0);
    add(1, 0, 0, 32'h0,       0, 0, 0, 32'h0,         1, 32'h10,       0, 32'h80,      NOP,        0);
    // Reset mid-transaction; response in first released cycle ignored.
    add(1, 0, 0, 32'h0,       1, 0, 0, 32'h0,         0, 32'h10,       0, 32'h80,      NOP,        0);
    add(0, 0, 0, 32'h0,       0, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,       NOP,        0);
    add(1, 0, 0, 32'h0,       0, 1, 0, 32'h0000_EEEE, 1, 32'h0,        0, 32'h0,       NOP,        0);
    add(1, 0, 0, 32'h0,       1, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,       NOP,        0);
    add(1, 0, 0, 32'h0,       0, 1, 0, A|32'h0,       1, 32'h4,        1, 32'h0,       A|32'h0,    0);
    // Redirect alignment and pc wrap at the top of the address space.
    add(1, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 32'h0,       1, 32'hFFFF_FFFC, 0, 32'h0,      NOP,        0);
    add(1, 0, 0, 32'h0,       1, 0, 0, 32'h0,         0, 32'hFFFF_FFFC, 0, 32'h0,      NOP,        0);
    add(1, 0, 0, 32'h0,       0, 1, 0, A|32'hFC,      1, 32'h0,        1, 32'hFFFF_FFFC, A|32'hFC, 0);
`ifdef IF_FAULT_EN
    // Error response at 0x8: fault presented, fetch halts until redirect to 0.
    add(0, 0, 0, 32'h0,       0, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,       NOP,        0);
    add(1, 0, 0, 32'h0,       0, 0, 0, 32'h0,         1, 32'h0,        0, 32'h0,       NOP,        0);
    add(1, 0, 0, 32'h0,       1, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,       NOP,        0);
    add(1, 0, 0, 32'h0,       0, 1, 0, A|32'h0,       1, 32'h4,        1, 32'h0,       A|32'h0,    0);
    add(1, 0, 0, 32'h0,       1, 0, 0, 32'h0,         0, 32'h4,        0, 32'h0,       NOP,        0);
    add(1, 0, 0, 32'h0,       0, 1, 0, A|32'h4,       1, 32'h8,        1, 32'h4,       A|32'h4,    0);
    add(1, 0, 0, 32'h0,       1, 0, 0, 32'h0,         0, 32'h8,        0, 32'h4,       NOP,        0);
    add(1, 0, 0, 32'h0,       0, 1, 1, 32'h1234_5678, 0, 32'hC,        1, 32'h8,       32'h0,      1);
    add(1, 0, 0, 32'h0,       1, 0, 0, 32'h0,         0, 32'hC,        0, 32'h8,       NOP,        1);
    add(1, 0, 0, 32'h0,       0, 0, 0, 32'h0,         0, 32'hC,        0, 32'h8,       NOP,        1);
    add(1, 0, 1, 32'h0,       0, 0, 0, 32'h0,         1, 32'h0,        0, 32'h8,       NOP,        0);
    add(1, 0, 0, 32'h0,       1, 0, 0, 32'h0,         0, 32'h0,        0, 32'h8,       NOP,        0);
    add(1, 0, 0, 32'h0,       0, 1, 0, A|32'h0,       1, 32'h4,        1, 32'h0,       A|32'h0,    0);
`endif

    foreach (vecs[i]) begin
      @(negedge clk);
      rst           = vecs[i].rst;
      i_stall       = vecs[i].stall;
      i_redirect    = vecs[i].redir;
      i_redirect_pc = vecs[i].rpc;
      i_imem_gnt    = vecs[i].gnt;
      i_imem_rvalid = vecs[i].rv;
      i_imem_rdata  = vecs[i].rdata;
`ifdef IF_FAULT_EN
      i_imem_err    = vecs[i].err;
`endif
      @(posedge clk);
      #1;
      check($sformatf("v%0d imem_req", i),  32'(o_imem_req),  32'(vecs[i].e_req));
      check($sformatf("v%0d imem_addr", i), o_imem_addr,       vecs[i].e_addr);
      check($sformatf("v%0d valid_out", i), 32'(o_valid_out), 32'(vecs[i].e_valid));
      check($sformatf("v%0d pc_out", i),    o_pc_out,          vecs[i].e_pc);
      check($sformatf("v%0d instr_out", i), o_instruction_out, vecs[i].e_ins);
`ifdef IF_FAULT_EN
      check($sformatf("v%0d fault_out", i), 32'(o_fault_out), 32'(vecs[i].e_fault));
`endif
    end

    // Streaming sequence: redirect to 0x300, then a memory that always grants
    // and answers one cycle later, under a stall pattern. Every consumed
    // instruction must be the next sequential PC with matching data.
    @(negedge clk);
    i_stall = 1'b0; i_redirect = 1'b1; i_redirect_pc = 32'h300;
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0;
`ifdef IF_FAULT_EN
    i_imem_err = 1'b0;
`endif
    @(posedge clk);
    #1;
    check("stream start addr", o_imem_addr, 32'h300);
    check("stream start req",  32'(o_imem_req), 32'd1);

    pend      = 1'b0;
    pend_addr = '0;
    exp_pc    = 32'h300;
    consumed  = 0;
    pat       = 60'h000_F03C_0E1F_00C3;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      i_redirect    = 1'b0;
      i_stall       = pat[k];
      i_imem_gnt    = 1'b1;
      i_imem_rvalid = pend;
      i_imem_rdata  = pend_addr ^ K;
      if (o_valid_out && !i_stall) begin
        check($sformatf("stream pc #%0d", consumed),    o_pc_out,          exp_pc);
        check($sformatf("stream instr #%0d", consumed), o_instruction_out, exp_pc ^ K);
        exp_pc   = exp_pc + 32'd4;
        consumed = consumed + 1;
      end
      pend      = o_imem_req;
      pend_addr = o_imem_addr;
    end
    check("stream progress (>=15 consumed)", 32'(consumed >= 15), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
